// File: rtl/alu_issue_sequencer.sv
// rtl/alu_issue_sequencer.sv - tagged command front end and response buffer for the registered ALU control block
//
// Accepts tagged ALU commands, registers them onto the ALU control inputs,
// tracks each command through a fixed-latency pipeline, captures the ALU
// result/flags when the command emerges, and buffers tagged responses in a
// FIFO with valid/ready back-pressure. Credit accounting (in-flight + buffered)
// guarantees the FIFO never overflows, so no result is ever dropped.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_a/b/op/cin/tag          command operands, opcode, carry-in, tag
//   alu_a/b/instruction/cin     registered drive into the ALU control block
//   alu_result/cout/ovf/z       result and flags returned by the ALU
//   rsp_valid/rsp_ready         response handshake
//   rsp_result/cout/ovf/z/err   response payload (cout masked, err = divide-by-zero)
//   rsp_tag                     tag of the originating command
//   busy                        any command in flight or buffered
//   err_count                   saturating count of error responses pushed

module alu_issue_sequencer #(
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [3:0]       cmd_op,
    input  logic             cmd_cin,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_instruction,
    output logic             alu_cin,
    input  logic [31:0]      alu_result,
    input  logic             alu_cout,
    input  logic             alu_ovf,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             rsp_z,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [15:0]      err_count
);

    localparam int PIPE_D = ALU_LAT - 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [3:0]       op;
        logic             err;
    } pipe_t;

    typedef struct packed {
        logic [31:0]      result;
        logic             cout;
        logic             ovf;
        logic             z;
        logic             err;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    pipe_t [PIPE_D-1:0] pipe;
    pipe_t              head;
    rsp_t               mem [DEPTH];
    rsp_t               push_data;
    rsp_t               rd_data;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] inflight_count;
    logic [CNT_W:0]   credit_used;

    logic accept;
    logic push;
    logic pop;
    logic cmd_err;

    // Credit covers both buffered and still-in-flight responses, so every
    // accepted command is guaranteed a FIFO slot when it emerges.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_count};
    assign cmd_ready   = credit_used < (CNT_W+1)'(DEPTH);
    assign busy        = credit_used != '0;

    assign accept  = cmd_valid & cmd_ready;
    assign cmd_err = (cmd_op == OP_DIV) && (cmd_b == 32'd0);

    assign head = pipe[PIPE_D-1];
    assign push = head.valid;

    assign rsp_valid = fifo_count != '0;
    assign pop       = rsp_valid & rsp_ready;

    // Divide-by-zero overrides whatever the ALU produced; carry-out is only
    // meaningful for add/subtract and is cleared for every other opcode.
    always_comb begin
        push_data.tag    = head.tag;
        push_data.err    = head.err;
        push_data.result = alu_result;
        push_data.ovf    = alu_ovf;
        push_data.z      = alu_z;
        push_data.cout   = ((head.op == OP_ADD) || (head.op == OP_SUB)) ? alu_cout : 1'b0;
        if (head.err) begin
            push_data.result = 32'd0;
            push_data.ovf    = 1'b0;
            push_data.z      = 1'b1;
            push_data.cout   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a           <= '0;
            alu_b           <= '0;
            alu_instruction <= OP_NOP;
            alu_cin         <= 1'b0;
            pipe            <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_count      <= '0;
            inflight_count  <= '0;
            err_count       <= '0;
        end else begin
            if (accept) begin
                alu_a           <= cmd_a;
                alu_b           <= cmd_b;
                alu_instruction <= cmd_op;
                alu_cin         <= cmd_cin;
            end else begin
                alu_instruction <= OP_NOP;
            end

            pipe[0] <= {accept, cmd_tag, cmd_op, cmd_err};
            for (int i = 1; i < PIPE_D; i++) begin
                pipe[i] <= pipe[i-1];
            end

            inflight_count <= inflight_count + CNT_W'(accept) - CNT_W'(push);
            fifo_count     <= fifo_count + CNT_W'(push) - CNT_W'(pop);

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (push && head.err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    // Storage needs no reset: rsp_valid gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign rd_data    = mem[rd_ptr];
    assign rsp_result = rd_data.result;
    assign rsp_cout   = rd_data.cout;
    assign rsp_ovf    = rd_data.ovf;
    assign rsp_z      = rd_data.z;
    assign rsp_err    = rd_data.err;
    assign rsp_tag    = rd_data.tag;

endmodule
